// File: rtl/btb_pkg.sv
// -----------------------------------------------------------------------------
// btb_pkg
// Shared types and helpers for the branch target buffer.
//   WORD_W          : machine word width (PCs and targets).
//   btb_state_t     : 2-bit saturating direction counter, MSB = predict taken.
//   btb_next_state  : one saturating step of the counter toward the outcome.
// -----------------------------------------------------------------------------
package btb_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    STRONG_NOT_TAKEN = 2'b00,
    WEAK_NOT_TAKEN   = 2'b01,
    WEAK_TAKEN       = 2'b10,
    STRONG_TAKEN     = 2'b11
  } btb_state_t;

  // Increment on taken, decrement on not-taken, hold at either end.
  function automatic btb_state_t btb_next_state(input btb_state_t state,
                                                input logic       taken);
    btb_state_t nxt;
    nxt = state;
    if (taken && (state != STRONG_TAKEN)) begin
      nxt = btb_state_t'(state + 2'd1);
    end else if (!taken && (state != STRONG_NOT_TAKEN)) begin
      nxt = btb_state_t'(state - 2'd1);
    end
    return nxt;
  endfunction

endpackage : btb_pkg

// File: rtl/btb_predictor_if.sv
// -----------------------------------------------------------------------------
// btb_predictor_if
// Fetch-side lookup, resolve-side update, flush and statistics of the BTB.
//   master : the pipeline (drives flush, lookup_*, upd_*; observes pred_*, stat_*)
//   slave  : the predictor
// -----------------------------------------------------------------------------
interface btb_predictor_if #(
  parameter int CNT_W = 32
);
  import btb_pkg::*;

  logic              flush;
  logic              lookup_en;
  logic [WORD_W-1:0] lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [WORD_W-1:0] pred_target;
  logic              upd_en;
  logic [WORD_W-1:0] upd_pc;
  logic [WORD_W-1:0] upd_target;
  logic              upd_taken;
  logic              upd_mispredict;
  logic [CNT_W-1:0]  stat_lookups;
  logic [CNT_W-1:0]  stat_mispredicts;

  modport master (
    output flush, lookup_en, lookup_pc,
    output upd_en, upd_pc, upd_target, upd_taken, upd_mispredict,
    input  pred_hit, pred_taken, pred_target,
    input  stat_lookups, stat_mispredicts
  );

  modport slave (
    input  flush, lookup_en, lookup_pc,
    input  upd_en, upd_pc, upd_target, upd_taken, upd_mispredict,
    output pred_hit, pred_taken, pred_target,
    output stat_lookups, stat_mispredicts
  );

endinterface : btb_predictor_if

// File: rtl/btb_sat_counter.sv
// -----------------------------------------------------------------------------
// btb_sat_counter
// Saturating up-counter used for the BTB statistics.
//   clk   : clock
//   clear : synchronous clear, dominates en
//   en    : count this cycle
//   count : current value, holds at all-ones
// -----------------------------------------------------------------------------
module btb_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule : btb_sat_counter

// File: rtl/btb_predictor.sv
// -----------------------------------------------------------------------------
// btb_predictor
// Direct-mapped branch target buffer with per-entry 2-bit direction counter.
//   CLK  : clock, all state changes on the rising edge
//   RST  : synchronous active-high reset
//   bus  : btb_predictor_if.slave -- combinational lookup on lookup_pc,
//          registered update from the resolve stage, flush, stats
// Parameters: IDX_W (index bits), CNT_W (stats width), INIT_STATE (state
// written on allocation and reset).
// -----------------------------------------------------------------------------
module btb_predictor
  import btb_pkg::*;
#(
  parameter int         IDX_W      = 4,
  parameter int         CNT_W      = 32,
  parameter btb_state_t INIT_STATE = WEAK_TAKEN
) (
  input  logic           CLK,
  input  logic           RST,
  btb_predictor_if.slave bus
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = WORD_W - IDX_W - 2;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  btb_state_t        state_q  [ENTRIES];
  logic [WORD_W-1:0] target_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;

  // Byte offset within the instruction word never participates.
  logic unused_pc_low;
  assign unused_pc_low = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

  assign lk_idx = bus.lookup_pc[IDX_W+1:2];
  assign lk_tag = bus.lookup_pc[WORD_W-1:IDX_W+2];
  assign up_idx = bus.upd_pc[IDX_W+1:2];
  assign up_tag = bus.upd_pc[WORD_W-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Lookup reads registered state only, so a same-cycle update is not seen.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    bus.pred_hit    = 1'b0;
    bus.pred_taken  = 1'b0;
    bus.pred_target = bus.lookup_pc + WORD_W'(4);
    if (valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag)) begin
      bus.pred_hit   = 1'b1;
      bus.pred_taken = state_q[lk_idx][1];
      if (state_q[lk_idx][1]) begin
        bus.pred_target = target_q[lk_idx];
      end
    end
  end

  // Priority: RST > flush > update.
  // NOTE: the entry arrays are reset in full because cleared targets and a
  // known counter state are part of the reset contract; a table that only
  // needed valid bits cleared would leave the payload arrays unreset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        state_q[i]  <= INIT_STATE;
        target_q[i] <= '0;
      end
    end else if (bus.flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (bus.upd_en) begin
      if (up_hit) begin
        state_q[up_idx] <= btb_next_state(state_q[up_idx], bus.upd_taken);
        if (bus.upd_taken) begin
          target_q[up_idx] <= bus.upd_target;
        end
      end else if (bus.upd_taken) begin
        // Allocate-on-taken: evicts whatever occupies the slot.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        state_q[up_idx]  <= INIT_STATE;
        target_q[up_idx] <= bus.upd_target;
      end
    end
  end

  btb_sat_counter #(.W(CNT_W)) u_stat_lookups (
    .clk   (CLK),
    .clear (RST),
    .en    (bus.lookup_en),
    .count (bus.stat_lookups)
  );

  btb_sat_counter #(.W(CNT_W)) u_stat_mispredicts (
    .clk   (CLK),
    .clear (RST),
    .en    (bus.upd_en && bus.upd_mispredict),
    .count (bus.stat_mispredicts)
  );

endmodule : btb_predictor

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Parametrised branch target buffer with a 2-bit saturating direction counter per entry. It generalises the fixed 4-entry BTB to 2^IDX_W direct-mapped entries with full tag compare.
- Sits in the fetch stage. The lookup port is combinational on lookup_pc. The update port is written from the branch-resolve stage (EX/MEM).
- Adds flush, allocate-on-taken policy, and saturating lookup/mispredict statistics counters.

Parameters:
- IDX_W, 4, index bits; ENTRIES = 2^IDX_W (16 by default).
- CNT_W, 32, width of the statistics counters.
- INIT_STATE, WEAK_TAKEN, counter state written on allocation.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- flush  in  1  invalidate all entries on the next edge.
- lookup_en  in  1  fetch is issuing a lookup this cycle (gates stats only).
- lookup_pc  in  32  fetch PC.
- pred_hit  out  1  valid entry whose tag matches lookup_pc.
- pred_taken  out  1  pred_hit && counter[1].
- pred_target  out  32  entry target if pred_taken, else lookup_pc+4.
- upd_en  in  1  resolved branch this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_target  in  32  resolved target.
- upd_taken  in  1  actual branch outcome.
- upd_mispredict  in  1  the resolve stage detected a misprediction (stats only).
- stat_lookups  out  CNT_W  saturating count of lookup_en cycles.
- stat_mispredicts  out  CNT_W  saturating count of upd_en && upd_mispredict.

Behaviour:
- Address split:
  - index = pc[IDX_W+1:2].
  - tag = pc[31:IDX_W+2].
  - pc[1:0] ignored.
- Entry fields: valid, tag, state (2 bits), target (32 bits).
- Counter encoding:
  - STRONG_TAKEN = 2'b11
  - WEAK_TAKEN = 2'b10
  - WEAK_NOT_TAKEN = 2'b01
  - STRONG_NOT_TAKEN = 2'b00
  - Taken is predicted when state[1] = 1.
  - Increment on taken, decrement on not-taken, saturating at 11 and 00.
- Lookup:
  - Purely combinational from registered state, zero latency.
  - No write-to-read bypass: an update at edge N becomes visible to lookups from cycle N+1 onward.
- Update (upd_en = 1), at the rising edge:
  - Hit (valid && tag match):
    - state steps toward upd_taken.
    - If upd_taken, target <= upd_target.
    - If not taken, target is unchanged.
  - Miss && upd_taken:
    - Allocate, overwriting the indexed entry whether valid or not: valid = 1, tag, target = upd_target, state = INIT_STATE.
  - Miss && !upd_taken: no change (not-taken branches are never allocated).
- Flush: clears all valid bits and leaves stats unchanged.
  - Flush and upd_en in the same cycle: flush wins and the update is dropped.
- Stats:
  - Each counter increments by 1 per qualifying cycle.
  - Each holds at 2^CNT_W-1 (no wrap).
  - Cleared only by RST.
- Reset (RST = 1 at the edge):
  - All valid = 0, all states = INIT_STATE, targets = 0, stats = 0.
  - Outputs immediately after reset: pred_hit = 0, pred_taken = 0, pred_target = lookup_pc+4, stats = 0.
  - RST overrides flush and upd_en.
  - RST asserted mid-stream discards any update in that cycle.
- Lookup and update may target the same index in the same cycle; the lookup returns the pre-update contents.

Decomposition:
- Shared package btb_pkg holds:
  - btb_state_t as an explicit 2-bit enum with the encoding above.
  - Function btb_next_state(state, taken) implementing the saturating step.
  - Localparam WORD_W = 32 (from cpu_types_pkg word_t).
- Entry arrays are declared in the module, because they are parameter-sized.
- One natural sub-module: btb_sat_counter, a parametrised CNT_W saturating incrementer (en, clear). It is instantiated twice for the stats.

Test Plan:
- Reset, then lookup_pc = 0x0000_0040 → pred_hit = 0, pred_taken = 0, pred_target = 0x0000_0044; both stats = 0.
- Allocate: upd_pc = 0x40, upd_taken = 1, upd_target = 0x100 → same-cycle lookup of 0x40 still misses; next cycle pred_hit = 1, pred_taken = 1, pred_target = 0x100.
- Hysteresis on 0x40: two not-taken updates (WT→WNT→SNT) → pred_taken = 0, pred_target = 0x44, pred_hit = 1. One taken update (→WNT) → still not taken. A second taken update → WT, pred_taken = 1.
- Alias with IDX_W = 4: 0x40 allocated; lookup 0x80 (same index 0) → miss. Taken update of 0x80 with target 0x200 → 0x80 hits with 0x200, 0x40 now misses. Not-taken update of 0xC0 → no change.
- Flush with simultaneous taken update of 0x300 → next cycle every lookup misses, including 0x300. Stats are unchanged.
- CNT_W = 4:
  - 20 cycles of lookup_en → stat_lookups = 15, held.
  - 3 updates with upd_mispredict = 1 → stat_mispredicts = 3.
  - RST pulse → both 0.
